// File: rtl/host_loader_if.sv
// Host byte-stream handshake into the loader.
// Host drives valid/data/reuse_w; loader returns ready.
interface host_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       reuse_w;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output reuse_w,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  reuse_w,
    output in_ready
  );
endinterface

// File: rtl/host_loader.sv
// Host write path into the 2x2 systolic tile: byte-serial operand
// load into an 8-byte bank, then en/mmu_cycle sequencing for the feeder.
module host_loader #(
  parameter int RUN_CYCLES = 7
) (
  input  logic          clk,
  input  logic          rst,
  host_loader_if.slave  bus,
  input  logic          abort,
  output logic [7:0]    weight0,
  output logic [7:0]    weight1,
  output logic [7:0]    weight2,
  output logic [7:0]    weight3,
  output logic [7:0]    input0,
  output logic [7:0]    input1,
  output logic [7:0]    input2,
  output logic [7:0]    input3,
  output logic          en,
  output logic [2:0]    mmu_cycle,
  output logic          busy,
  output logic          weights_valid,
  output logic [2:0]    load_count
);

  localparam logic [2:0] LAST = 3'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] cnt_n;
  logic [2:0] cyc_n;
  logic       wv_n;
  logic       wr;
  logic [2:0] wr_idx;
  logic       xfer;
  logic [7:0] ops [8];

  assign bus.in_ready = (state != RUN);
  assign xfer = bus.in_valid && bus.in_ready;
  assign en   = (state == RUN);
  assign busy = (state != IDLE);

  assign weight0 = ops[0];
  assign weight1 = ops[1];
  assign weight2 = ops[2];
  assign weight3 = ops[3];
  assign input0  = ops[4];
  assign input1  = ops[5];
  assign input2  = ops[6];
  assign input3  = ops[7];

  // State, counters and weights_valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      load_count    <= 3'd0;
      mmu_cycle     <= 3'd0;
      weights_valid <= 1'b0;
    end else begin
      state         <= state_n;
      load_count    <= cnt_n;
      mmu_cycle     <= cyc_n;
      weights_valid <= wv_n;
    end
  end

  // Next-state, counter updates and bank write select.
  // abort wins over a simultaneous transfer in every state.
  always_comb begin
    state_n = state;
    cnt_n   = load_count;
    cyc_n   = mmu_cycle;
    wv_n    = weights_valid;
    wr      = 1'b0;
    wr_idx  = load_count;
    unique case (state)
      IDLE: begin
        if (!abort && xfer) begin
          state_n = LOAD;
          wr      = 1'b1;
          if (bus.reuse_w && weights_valid) begin
            wr_idx = 3'd4;
            cnt_n  = 3'd5;
          end else begin
            wr_idx = 3'd0;
            cnt_n  = 3'd1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else if (xfer) begin
          wr    = 1'b1;
          cnt_n = load_count + 3'd1;
          if (load_count == 3'd3) wv_n = 1'b1;
          if (load_count == 3'd7) begin
            state_n = RUN;
            cyc_n   = 3'd0;
          end
        end
      end
      RUN: begin
        if (abort || mmu_cycle == LAST) begin
          state_n = IDLE;
          cyc_n   = 3'd0;
        end else begin
          cyc_n = mmu_cycle + 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
        cyc_n   = 3'd0;
      end
    endcase
  end

  // Operand bank; only written on accepted bytes outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ops[i] <= 8'h00;
    end else if (wr) begin
      ops[wr_idx] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_host_loader.sv
// Bench for host_loader: vector table for a gapped full load,
// hand sequences for reuse/abort/reset, operand scoreboard on en rise.
module tb_host_loader;

  logic       clk;
  logic       rst;
  logic       abort;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       en;
  logic [2:0] mmu_cycle;
  logic       busy;
  logic       weights_valid;
  logic [2:0] load_count;

  host_loader_if hif ();

  host_loader #(.RUN_CYCLES(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (hif),
    .abort         (abort),
    .weight0       (weight0),
    .weight1       (weight1),
    .weight2       (weight2),
    .weight3       (weight3),
    .input0        (input0),
    .input1        (input1),
    .input2        (input2),
    .input3        (input3),
    .en            (en),
    .mmu_cycle     (mmu_cycle),
    .busy          (busy),
    .weights_valid (weights_valid),
    .load_count    (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q [$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] cnt;
    logic       bsy;
    logic       wv;
    logic       en;
    logic [2:0] cyc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] a,
                      input logic [2:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] a,
                      input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic ru);
    hif.in_valid = 1'b1;
    hif.in_data  = d;
    hif.reuse_w  = ru;
    tick();
    hif.in_valid = 1'b0;
    hif.reuse_w  = 1'b0;
  endtask

  task automatic wait_cyc(input logic [2:0] c);
    int n;
    n = 0;
    while (!(en && mmu_cycle == c) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL wait_cyc got=timeout want=%0d", c);
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL wait_idle got=timeout want=idle");
    end
  endtask

  task automatic pulse_rst;
    #2 rst = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk3("rst_cnt", load_count, 3'd0);
    chk8("rst_w0", weight0, 8'h00);
    chk1("rst_wv", weights_valid, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("rel_ready", hif.in_ready, 1'b1);
  endtask

  // Scoreboard: compare the operand bank on the first RUN cycle.
  initial begin
    forever begin
      tick();
      if (en && mmu_cycle == 3'd0 && !rst) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty got=run want=none");
        end else begin
          chk64("sb_ops",
                {weight0, weight1, weight2, weight3,
                 input0, input1, input2, input3},
                exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 8'h03, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 8'h04, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 8'hEE, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 8'hEE, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 8'h05, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{1'b1, 8'h06, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{1'b1, 8'h07, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{1'b1, 8'h08, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0};
    tbl[10] = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[11] = '{1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd2};
    tbl[12] = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd3};
    tbl[13] = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd4};
    tbl[14] = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd5};
    tbl[15] = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd6};
    tbl[16] = '{1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0};

    rst          = 1'b1;
    abort        = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data  = 8'h00;
    hif.reuse_w  = 1'b0;

    #12;
    chk1("reset_en", en, 1'b0);
    chk3("reset_cyc", mmu_cycle, 3'd0);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("reset_ready", hif.in_ready, 1'b1);

    send(8'h5A, 1'b0);
    send(8'h5B, 1'b0);
    chk8("pre_w0", weight0, 8'h5A);
    chk3("pre_cnt", load_count, 3'd2);
    pulse_rst();

    send(8'hAA, 1'b1);
    chk8("noreuse_w0", weight0, 8'hAA);
    chk3("noreuse_cnt", load_count, 3'd1);
    chk8("noreuse_i0", input0, 8'h00);
    pulse_rst();

    for (int i = 0; i < 17; i++) begin
      if (i == 9) exp_q.push_back(64'h0102030405060708);
      hif.in_valid = tbl[i].v;
      hif.in_data  = tbl[i].d;
      tick();
      hif.in_valid = 1'b0;
      chk1($sformatf("v%0d_ready", i), hif.in_ready, tbl[i].rdy);
      chk3($sformatf("v%0d_cnt", i), load_count, tbl[i].cnt);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      chk1($sformatf("v%0d_wv", i), weights_valid, tbl[i].wv);
      chk1($sformatf("v%0d_en", i), en, tbl[i].en);
      chk3($sformatf("v%0d_cyc", i), mmu_cycle, tbl[i].cyc);
    end
    chk64("full_ops",
          {weight0, weight1, weight2, weight3,
           input0, input1, input2, input3},
          64'h0102030405060708);

    send(8'h11, 1'b1);
    chk3("reuse_cnt5", load_count, 3'd5);
    chk8("reuse_i0", input0, 8'h11);
    chk8("reuse_w0", weight0, 8'h01);
    send(8'h12, 1'b0);
    chk3("reuse_cnt6", load_count, 3'd6);
    send(8'h13, 1'b0);
    chk3("reuse_cnt7", load_count, 3'd7);
    exp_q.push_back(64'h0102030411121314);
    send(8'h14, 1'b0);
    chk3("reuse_cnt0", load_count, 3'd0);
    chk1("reuse_en", en, 1'b1);
    wait_idle();
    chk8("reuse_w3", weight3, 8'h04);
    chk8("reuse_i3", input3, 8'h14);

    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b0);
    chk3("ab_cnt5", load_count, 3'd5);
    chk8("ab_i0", input0, 8'h25);
    abort        = 1'b1;
    hif.in_valid = 1'b1;
    hif.in_data  = 8'h55;
    tick();
    abort        = 1'b0;
    hif.in_valid = 1'b0;
    chk8("ab_i1_kept", input1, 8'h12);
    chk1("ab_busy", busy, 1'b0);
    chk3("ab_cnt0", load_count, 3'd0);
    chk1("ab_wv", weights_valid, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(64'h3132333435363738);
      send(8'h31 + 8'(i), 1'b0);
    end
    wait_cyc(3'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abrun_en", en, 1'b0);
    chk3("abrun_cyc", mmu_cycle, 3'd0);
    chk1("abrun_busy", busy, 1'b0);
    chk8("abrun_i3", input3, 8'h38);

    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(64'h3132333441424344);
      send(8'h41 + 8'(i), (i == 0) ? 1'b1 : 1'b0);
    end
    wait_cyc(3'd4);
    #2 rst = 1'b1;
    #1;
    chk1("rrun_en", en, 1'b0);
    chk3("rrun_cyc", mmu_cycle, 3'd0);
    chk8("rrun_w0", weight0, 8'h00);
    chk8("rrun_i3", input3, 8'h00);
    chk1("rrun_wv", weights_valid, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk1("rrun_ready", hif.in_ready, 1'b1);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_loader.md
Name: host_loader

Overview:
- Host-facing write path into the 2x2 systolic-array tile; the opposite direction to the feeder's byte-serial result readout.
- Accepts byte-serial weight and input operands from the host (RPi) with a valid/ready handshake and holds them in an 8-byte register bank.
- Drives weight0..3 and input0..3 to the feeder.
- Once a batch is complete, sequences the compute/readout phase by generating en and mmu_cycle for the feeder.

Parameters:
- RUN_CYCLES, 7: number of cycles in the RUN phase; mmu_cycle counts 0..RUN_CYCLES-1. Legal range 3..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- reuse_w  input  1  sampled with the first byte of a batch; requests reuse of the stored weights.
- abort  input  1  synchronous abort; returns to IDLE.
- in_ready  output  1  loader can accept a byte this cycle.
- weight0, weight1, weight2, weight3  output  8 each  stored weight bytes.
- input0, input1, input2, input3  output  8 each  stored input bytes.
- en  output  1  feeder enable; high only in RUN.
- mmu_cycle  output  3  compute/readout cycle index.
- busy  output  1  high in LOAD or RUN.
- weights_valid  output  1  a full weight set has been loaded since reset.
- load_count  output  3  index of the next byte to be written.

Behaviour:
- Reset (async):
  - State IDLE; all eight operand registers 0.
  - load_count 0, mmu_cycle 0, en 0, busy 0, weights_valid 0.
  - in_ready 1 once reset is released.
- Handshake:
  - A byte transfers on a rising edge with in_valid && in_ready.
  - in_ready = 1 in IDLE and LOAD, 0 in RUN (combinational from state).
  - in_valid while in_ready = 0 is ignored, with no side effects.
- Byte order, indexed by load_count:
  - 0 -> weight0, 1 -> weight1, 2 -> weight2, 3 -> weight3.
  - 4 -> input0, 5 -> input1, 6 -> input2, 7 -> input3.
  - Each transfer increments load_count (mod 8).
- States:
  - IDLE -> LOAD on the first transfer.
  - On that first transfer, if reuse_w = 1 and weights_valid = 1, the byte is written to input0 and load_count becomes 5 (weights untouched).
  - Otherwise the byte is written to weight0 and load_count becomes 1. reuse_w with weights_valid = 0 is ignored.
  - LOAD: each transfer writes the indexed register. The transfer at index 3 sets weights_valid = 1 on the same edge.
  - The transfer at index 7 sets state RUN, load_count 0, en 1, mmu_cycle 0 on that same edge. Latency: en is high in the cycle after the last byte is accepted.
  - RUN: mmu_cycle increments every cycle. On the edge where mmu_cycle == RUN_CYCLES-1: state IDLE, en 0, mmu_cycle 0.
  - en is therefore high for exactly RUN_CYCLES consecutive cycles.
- Operand stability: operand registers are never written in RUN. The feeder reads them combinationally during mmu_cycle 0..2.
- busy = (state != IDLE).
- abort:
  - In LOAD: next state IDLE, load_count 0.
  - In RUN: en 0, mmu_cycle 0, state IDLE.
  - Operand registers are retained in both cases.
  - If the index-3 transfer completed before the abort, weights_valid stays 1.
  - abort has priority over a simultaneous transfer; that byte is not written.
  - abort in IDLE: no effect.
- Reset mid-operation: immediate return to reset values regardless of state, including clearing weights_valid.
- mmu_cycle never exceeds RUN_CYCLES-1. Outside RUN it reads 0.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously. After release, in_ready 1, busy 0.
- Full load with gaps: send 0x01..0x08 with in_valid de-asserted for 2 cycles between bytes 3 and 4.
  - Required: weight0..3 = 01,02,03,04; input0..3 = 05,06,07,08.
  - weights_valid rises after byte 4; en rises the cycle after byte 8.
  - mmu_cycle goes 0..6 across 7 cycles, then IDLE. in_valid pulses during RUN leave all registers unchanged.
- Weight reuse: after the previous batch, send reuse_w = 1 with bytes 0x11..0x14.
  - Required: weights stay 01..04, inputs = 11..14, load_count goes 5,6,7,0, then RUN.
- Reuse without weights: after reset, send reuse_w = 1 with byte 0xAA.
  - Required: weight0 = AA, load_count = 1.
- Abort: after 5 bytes, assert abort together with in_valid and 0x55.
  - Required: 0x55 not written, state IDLE, load_count 0, weights_valid 1.
  - Then assert abort in RUN at mmu_cycle 3 -> en 0 the next cycle.
- Reset in RUN: assert rst at mmu_cycle 4 -> en 0, mmu_cycle 0, operands 0, weights_valid 0.
